ram_bus_master: RTL and testbench

- Host-side controller that sequences the shared 4-bit CPU bus (data, sync, cmd_n) to issue RAM-chip transactions on behalf of a single requester.
- Each request becomes one SRC instruction cycle followed by one RAM I/O instruction cycle (8 clocks each), in lock-step with the RAM chips' free-running cycle counter.
- Sits between the debug/host port and up to two RAM chips (p0 = 0/1) on the bus.

---
 rtl/ram_bus_master_if.sv | 25 ++
 rtl/ram_bus_master.sv | 203 ++++++++++++++++++++
 tb/tb_ram_bus_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_master_if.sv
// Request/response handshake between a host-side requester and ram_bus_master.
// The requester uses the master modport; ram_bus_master uses the slave modport.
interface ram_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic       req_chip;
  logic [1:0] req_reg;
  logic [3:0] req_char;
  logic [1:0] req_idx;
  logic [3:0] req_wdata;
  logic       resp_valid;
  logic [3:0] resp_rdata;
  logic       resp_err;

  modport master (
    output req_valid, req_op, req_chip, req_reg, req_char, req_idx, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_chip, req_reg, req_char, req_idx, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ram_bus_master.sv
// Host-side sequencer for the shared 4-bit RAM bus (data/sync/cmd_n).
// Each request becomes an SRC instruction cycle followed by a RAM I/O
// instruction cycle, locked to the free-running 8-clock cycle counter that the
// RAM chips also run.
// Optional build macro: RAM_BUS_MASTER_SRC_CACHE_EN -- remembers the last SRC
// address and skips the SRC cycle when a request targets the same address.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; invalid ops are answered from here
// WAIT  | request latched, waiting for cycle 7 to start an instruction
// SRC   | SRC cycle: chip/reg at cycle 6, char at cycle 7
// IO    | RAM I/O cycle: OPA at cycle 4, write data / read sample at 6
module ram_bus_master #(
  parameter bit INVALID_OP_ERR = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  ram_bus_master_if.slave  host,
  inout  wire  [3:0]       data,
  output logic             sync,
  output logic             cmd_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SRC  = 2'd2,
    IO   = 2'd3
  } state_t;

  localparam logic [2:0] OP_WRM = 3'd0;
  localparam logic [2:0] OP_WMP = 3'd1;
  localparam logic [2:0] OP_WRN = 3'd2;
  localparam logic [2:0] OP_RDM = 3'd3;
  localparam logic [2:0] OP_RDN = 3'd4;

  state_t     state;
  logic [2:0] cycle;

  logic [2:0] op_q;
  logic       chip_q;
  logic [1:0] reg_q;
  logic [3:0] char_q;
  logic [1:0] idx_q;
  logic [3:0] wdata_q;
  logic       hit_q;

  logic       data_oe;
  logic [3:0] data_out;
  logic       resp_valid_q;
  logic [3:0] resp_rdata_q;
  logic       resp_err_q;

  logic       op_invalid;
  logic       is_read;
  logic       src_hit;
  logic [3:0] opa;

`ifdef RAM_BUS_MASTER_SRC_CACHE_EN
  logic       cache_valid;
  logic       last_chip;
  logic [1:0] last_reg;
  logic [3:0] last_char;

  assign src_hit = cache_valid
                && (host.req_chip == last_chip)
                && (host.req_reg  == last_reg)
                && (host.req_char == last_char);
`else
  assign src_hit = 1'b0;
`endif

  assign op_invalid = (host.req_op > OP_RDN);
  assign is_read    = (op_q == OP_RDM) || (op_q == OP_RDN);

  // sync is a pure decode of the cycle counter, independent of state
  assign sync = (cycle == 3'd7);

  // The bus is let go in the very cycle reset is raised, not one clock later
  assign data = (data_oe && !reset) ? data_out : 4'hz;

  assign host.req_ready  = (state == IDLE);
  assign host.resp_valid = resp_valid_q;
  assign host.resp_rdata = resp_rdata_q;
  assign host.resp_err   = resp_err_q;

  // OPA nibble for the latched RAM I/O instruction
  always_comb begin
    opa = 4'h0;
    case (op_q)
      OP_WRM:  opa = 4'h0;
      OP_WMP:  opa = 4'h1;
      OP_WRN:  opa = {2'b01, idx_q};
      OP_RDM:  opa = 4'h9;
      OP_RDN:  opa = {2'b11, idx_q};
      default: opa = 4'h0;
    endcase
  end

  // Sequencer: cycle counter, state machine and all registered bus/response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cycle        <= 3'd0;
      cmd_n        <= 1'b1;
      data_oe      <= 1'b0;
      data_out     <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 4'h0;
      resp_err_q   <= 1'b0;
      hit_q        <= 1'b0;
`ifdef RAM_BUS_MASTER_SRC_CACHE_EN
      cache_valid  <= 1'b0;
`endif
    end else begin
      cycle        <= cycle + 3'd1;
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (host.req_valid) begin
            op_q    <= host.req_op;
            chip_q  <= host.req_chip;
            reg_q   <= host.req_reg;
            char_q  <= host.req_char;
            idx_q   <= host.req_idx;
            wdata_q <= host.req_wdata;
            hit_q   <= src_hit;
            if (op_invalid) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= INVALID_OP_ERR;
            end else if (cycle == 3'd7) begin
              // Accepting in cycle 7 already satisfies the WAIT exit
              // condition, so the instruction starts with the next cycle 0.
              state <= src_hit ? IO : SRC;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cycle == 3'd7) state <= hit_q ? IO : SRC;
        end
        SRC: begin
          case (cycle)
            3'd5: begin
              cmd_n    <= 1'b0;
              data_oe  <= 1'b1;
              data_out <= {1'b0, chip_q, reg_q};
            end
            3'd6: begin
              cmd_n    <= 1'b1;
              data_out <= char_q;
            end
            3'd7: begin
              data_oe <= 1'b0;
              state   <= IO;
`ifdef RAM_BUS_MASTER_SRC_CACHE_EN
              cache_valid <= 1'b1;
              last_chip   <= chip_q;
              last_reg    <= reg_q;
              last_char   <= char_q;
`endif
            end
            default: ;
          endcase
        end
        IO: begin
          case (cycle)
            3'd3: begin
              cmd_n    <= 1'b0;
              data_oe  <= 1'b1;
              data_out <= opa;
            end
            3'd4: begin
              cmd_n   <= 1'b1;
              data_oe <= 1'b0;
            end
            3'd5: begin
              // Reads leave the bus free so the selected RAM can drive it
              if (!is_read) begin
                data_oe  <= 1'b1;
                data_out <= wdata_q;
              end
            end
            3'd6: begin
              data_oe <= 1'b0;
              if (is_read) resp_rdata_q <= data;
            end
            3'd7: begin
              state        <= IDLE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master. A bus-functional model of two RAM
// chips answers on the shared bus; a reference model predicts every bus event
// and response from the request stream and the cycle position of the accept.
module tb_ram_bus_master;
  localparam bit INV_ERR = 1'b1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  wire  [3:0] data;
  logic sync;
  logic cmd_n;

  ram_bus_master_if bus_if ();

  ram_bus_master #(.INVALID_OP_ERR(INV_ERR)) dut (
    .clock (clock),
    .reset (reset),
    .host  (bus_if),
    .data  (data),
    .sync  (sync),
    .cmd_n (cmd_n)
  );

  always #5 clock = ~clock;

  int t = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;
  bit in_reset = 1'b1;
  int busy_until = 0;
  int last_io = 0;

  always @(posedge clock) t <= t + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, exp);
    end
  endtask

  // ---------------- RAM chip bus-functional model ----------------
  logic [2:0] bfm_cyc = 3'd0;
  logic       src_pend = 1'b0, io_act = 1'b0, sel_chip = 1'b0;
  logic [1:0] sel_reg = 2'd0;
  logic [3:0] sel_char = 4'h0, io_op = 4'h0;
  logic [3:0] bfm_mem [2][4][16];
  logic [3:0] bfm_stat[2][4][4];
  logic [3:0] bfm_out [2];
  logic       bfm_drv;
  logic [3:0] bfm_val;

  assign bfm_drv = io_act && (bfm_cyc == 3'd6) && (io_op == 4'h9 || io_op[3:2] == 2'b11);
  always_comb begin
    bfm_val = 4'h0;
    if (io_op == 4'h9) bfm_val = bfm_mem[sel_chip][sel_reg][sel_char];
    else               bfm_val = bfm_stat[sel_chip][sel_reg][io_op[1:0]];
  end
  assign data = bfm_drv ? bfm_val : 4'hz;

  always @(posedge clock) begin
    if (reset) begin
      bfm_cyc  <= 3'd0;
      src_pend <= 1'b0;
      io_act   <= 1'b0;
    end else begin
      bfm_cyc <= bfm_cyc + 3'd1;
      if (bfm_cyc == 3'd6 && !cmd_n) begin
        src_pend <= 1'b1;
        sel_chip <= data[2];
        sel_reg  <= data[1:0];
      end
      if (bfm_cyc == 3'd7 && src_pend) begin
        sel_char <= data;
        src_pend <= 1'b0;
      end
      if (bfm_cyc == 3'd4 && !cmd_n) begin
        io_act <= 1'b1;
        io_op  <= data;
      end
      if (bfm_cyc == 3'd6 && io_act) begin
        io_act <= 1'b0;
        if (io_op == 4'h0)             bfm_mem[sel_chip][sel_reg][sel_char] <= data;
        else if (io_op == 4'h1)        bfm_out[sel_chip] <= data;
        else if (io_op[3:2] == 2'b01)  bfm_stat[sel_chip][sel_reg][io_op[1:0]] <= data;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [3:0] ref_mem [2][4][16];
  logic [3:0] ref_stat[2][4][4];
  logic [3:0] ref_out [2];
  logic [3:0] ref_last_rd = 4'h0;
  bit         c_valid = 1'b0;
  logic       c_chip;
  logic [1:0] c_reg;
  logic [3:0] c_char;

  typedef struct { int t; logic [3:0] rdata; logic err; } resp_t;
  typedef struct { int t; logic cmd_low; logic [3:0] val; } ev_t;
  resp_t resp_q[$];
  ev_t   ev_q[$];

  initial begin
    for (int c = 0; c < 2; c++) begin
      bfm_out[c] = 4'h0;
      ref_out[c] = 4'h0;
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 16; k++) begin
          bfm_mem[c][r][k] = 4'h0;
          ref_mem[c][r][k] = 4'h0;
        end
        for (int k = 0; k < 4; k++) begin
          bfm_stat[c][r][k] = 4'h0;
          ref_stat[c][r][k] = 4'h0;
        end
      end
    end
  end

  // Monitor: one sample per clock period, 1 time unit after the active edge
  always @(posedge clock) begin
    ev_t   e;
    resp_t r;
    #1;
    if (!in_reset) begin
      chk("sync", int'(sync), int'(((t - t0) % 8) == 7));
      while (ev_q.size() > 0 && ev_q[0].t < t) begin
        e = ev_q.pop_front();
        chk("bus_event_missing", t, e.t);
      end
      if (!cmd_n || dut.data_oe) begin
        if (ev_q.size() == 0) begin
          chk("bus_unexpected_cmd_n", int'(cmd_n), 1);
          chk("bus_unexpected_drive", int'(dut.data_oe), 0);
        end else begin
          e = ev_q.pop_front();
          chk("bus_time", t, e.t);
          chk("bus_cmd_n", int'(cmd_n), int'(!e.cmd_low));
          chk("bus_drive", int'(dut.data_oe), 1);
          chk("bus_data", int'(data), int'(e.val));
        end
      end
      while (resp_q.size() > 0 && resp_q[0].t < t) begin
        r = resp_q.pop_front();
        chk("resp_missing", t, r.t);
      end
      if (bus_if.resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", int'(bus_if.resp_valid), 0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_time", t, r.t);
          chk("resp_rdata", int'(bus_if.resp_rdata), int'(r.rdata));
          chk("resp_err", int'(bus_if.resp_err), int'(r.err));
        end
      end
    end
  end

  // Called on a falling edge; holds reset for n periods and returns on a falling edge
  task automatic do_reset(input int n);
    reset = 1'b1;
    in_reset = 1'b1;
    ev_q.delete();
    resp_q.delete();
    c_valid = 1'b0;
    ref_last_rd = 4'h0;
    bus_if.req_valid = 1'b0;
    repeat (n) @(negedge clock);
    chk("rst_cmd_n", int'(cmd_n), 1);
    chk("rst_sync", int'(sync), 0);
    chk("rst_drive", int'(dut.data_oe), 0);
    chk("rst_resp_valid", int'(bus_if.resp_valid), 0);
    chk("rst_resp_rdata", int'(bus_if.resp_rdata), 0);
    chk("rst_resp_err", int'(bus_if.resp_err), 0);
    chk("rst_req_ready", int'(bus_if.req_ready), 1);
    reset = 1'b0;
    t0 = t;
    in_reset = 1'b0;
    busy_until = t;
  endtask

  // Called on a falling edge; returns on the falling edge after the accept
  task automatic issue(input logic [2:0] op, input logic chip, input logic [1:0] rg,
                       input logic [3:0] ch, input logic [1:0] idx, input logic [3:0] wd);
    int a, c, w, r, io_t;
    bit hit;
    logic [3:0] opa;
    resp_t rs;
    while (t < busy_until) @(negedge clock);
    chk("req_ready_idle", int'(bus_if.req_ready), 1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_chip  = chip;
    bus_if.req_reg   = rg;
    bus_if.req_char  = ch;
    bus_if.req_idx   = idx;
    bus_if.req_wdata = wd;
    a = t;
    c = (a - t0) % 8;
    if (op > 3'd4) begin
      rs.t = a + 1;
      rs.rdata = ref_last_rd;
      rs.err = INV_ERR;
      busy_until = a + 1;
    end else begin
      w = (c + 1) % 8;
      r = a + 1 + 16 + ((8 - w) % 8);
      hit = 1'b0;
`ifdef RAM_BUS_MASTER_SRC_CACHE_EN
      hit = c_valid && (c_chip == chip) && (c_reg == rg) && (c_char == ch);
      c_valid = 1'b1;
      c_chip = chip;
      c_reg = rg;
      c_char = ch;
`endif
      if (hit) r = r - 8;
      io_t = r - 8;
      last_io = io_t;
      if (!hit) begin
        ev_q.push_back('{t: io_t - 2, cmd_low: 1'b1, val: {1'b0, chip, rg}});
        ev_q.push_back('{t: io_t - 1, cmd_low: 1'b0, val: ch});
      end
      case (op)
        3'd0:    opa = 4'h0;
        3'd1:    opa = 4'h1;
        3'd2:    opa = 4'h4 + {2'b00, idx};
        3'd3:    opa = 4'h9;
        default: opa = 4'hC + {2'b00, idx};
      endcase
      ev_q.push_back('{t: io_t + 4, cmd_low: 1'b1, val: opa});
      case (op)
        3'd0: ref_mem[chip][rg][ch] = wd;
        3'd1: ref_out[chip] = wd;
        3'd2: ref_stat[chip][rg][idx] = wd;
        3'd3: ref_last_rd = ref_mem[chip][rg][ch];
        default: ref_last_rd = ref_stat[chip][rg][idx];
      endcase
      if (op <= 3'd2) ev_q.push_back('{t: io_t + 6, cmd_low: 1'b0, val: wd});
      rs.t = r;
      rs.rdata = ref_last_rd;
      rs.err = 1'b0;
      busy_until = r;
    end
    resp_q.push_back(rs);
    @(negedge clock);
    bus_if.req_valid = 1'b0;
    if (op <= 3'd4) chk("req_ready_busy", int'(bus_if.req_ready), 0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog t=%0d got=running want=finished", t);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 3'd0;
    bus_if.req_chip  = 1'b0;
    bus_if.req_reg   = 2'd0;
    bus_if.req_char  = 4'h0;
    bus_if.req_idx   = 2'd0;
    bus_if.req_wdata = 4'h0;
    @(negedge clock);
    do_reset(3);

    // idle: monitor checks sync and that the bus stays quiet
    for (int i = 0; i < 16; i++) begin
      chk("idle_cmd_n", int'(cmd_n), 1);
      chk("idle_req_ready", int'(bus_if.req_ready), 1);
      @(negedge clock);
    end

    issue(3'd0, 1'b0, 2'd2, 4'h5, 2'd0, 4'hA);
    issue(3'd3, 1'b0, 2'd2, 4'h5, 2'd0, 4'h0);
    issue(3'd2, 1'b1, 2'd1, 4'h0, 2'd3, 4'h7);
    issue(3'd4, 1'b1, 2'd1, 4'h0, 2'd3, 4'h0);
    issue(3'd1, 1'b0, 2'd0, 4'h0, 2'd0, 4'hC);
    issue(3'd0, 1'b1, 2'd3, 4'h9, 2'd0, 4'h3);
    while (t <= busy_until) @(negedge clock);
    chk("wmp_out0", int'(bfm_out[0]), 4'hC);
    chk("wmp_out1", int'(bfm_out[1]), 0);
    issue(3'd6, 1'b0, 2'd0, 4'h0, 2'd0, 4'h0);
    issue(3'd3, 1'b0, 2'd2, 4'h5, 2'd0, 4'h0);
    issue(3'd3, 1'b0, 2'd2, 4'h5, 2'd0, 4'h0);

    // reset in IO cycle 5 of a read: no response, bus released
    issue(3'd3, 1'b1, 2'd3, 4'h9, 2'd0, 4'h0);
    while (t < last_io + 5) @(negedge clock);
    do_reset(2);
    chk("abort_drive", int'(dut.data_oe), 0);
    repeat (24) @(negedge clock);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      if ($urandom_range(0, 9) == 0) op = 3'(5 + $urandom_range(0, 2));
      else                           op = 3'($urandom_range(0, 4));
      repeat ($urandom_range(0, 10)) @(negedge clock);
      issue(op, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    while (t <= busy_until + 2) @(negedge clock);
    chk("ev_q_empty", ev_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    for (int c = 0; c < 2; c++) begin
      chk("final_out", int'(bfm_out[c]), int'(ref_out[c]));
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 16; k++) chk("final_mem", int'(bfm_mem[c][r][k]), int'(ref_mem[c][r][k]));
        for (int k = 0; k < 4; k++)  chk("final_stat", int'(bfm_stat[c][r][k]), int'(ref_stat[c][r][k]));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
